// File: rtl/score_keeper_if.sv
// score_keeper_if: frame/point/start/pause controls in, BCD scores and match state out
interface score_keeper_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int DIGITS      = 2
);
  localparam int WW = NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1;
  logic                          frame_tick;
  logic [NUM_PLAYERS-1:0]        point;
  logic                          start;
  logic                          pause;
  logic [NUM_PLAYERS*DIGITS*4-1:0] bcd;
  logic [2:0]                    state;
  logic                          freeze;
  logic                          score_event;
  logic [WW-1:0]                 winner;
  logic                          winner_valid;
  modport master (
    output frame_tick, point, start, pause,
    input  bcd, state, freeze, score_event, winner, winner_valid
  );
  modport slave (
    input  frame_tick, point, start, pause,
    output bcd, state, freeze, score_event, winner, winner_valid
  );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: per-player saturating BCD scores with win detection, post-point hold and pause
module score_keeper #(
  parameter int NUM_PLAYERS = 2,
  parameter int DIGITS      = 2,
  parameter int WIN_SCORE   = 11,
  parameter int HOLD_FRAMES = 60
) (
  input logic Clk,
  input logic Reset,
  score_keeper_if.slave bus
);
  localparam int W  = DIGITS*4;
  localparam int WW = NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1;
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, HOLD = 3'd2, PAUSED = 3'd3, OVER = 3'd4} state_t;
  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int v;
    r = '0;
    v = n;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  localparam logic [W-1:0] MAX_BCD = to_bcd(10**DIGITS - 1);
  localparam logic [W-1:0] WIN_BCD = to_bcd(WIN_SCORE);
  // all-9s saturates; otherwise ripple the decimal carry from the ones digit
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    if (v == MAX_BCD) return v;
    for (int d = 0; d < DIGITS; d++) begin
      if (c) begin
        if (v[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
        else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction
  state_t                  r_state, r_saved;
  logic [7:0]              r_cnt;
  logic [NUM_PLAYERS*W-1:0] r_bcd;
  logic                    r_event;
  logic [WW-1:0]           r_winner;
  logic                    r_wvalid;
  logic [NUM_PLAYERS*W-1:0] w_inc;
  logic [NUM_PLAYERS-1:0]  w_hit;
  logic [WW-1:0]           w_win_idx;
  always_comb begin
    w_inc = r_bcd;
    w_hit = '0;
    w_win_idx = '0;
    for (int i = NUM_PLAYERS-1; i >= 0; i--) begin
      if (bus.point[i]) w_inc[i*W +: W] = bcd_inc(r_bcd[i*W +: W]);
      w_hit[i] = (WIN_SCORE != 0) && (w_inc[i*W +: W] == WIN_BCD);
      if (w_hit[i]) w_win_idx = WW'(i);
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_saved  <= PLAY;
      r_cnt    <= '0;
      r_bcd    <= '0;
      r_event  <= 1'b0;
      r_winner <= '0;
      r_wvalid <= 1'b0;
    end else begin
      r_event <= 1'b0;
      if (bus.start) begin
        r_state  <= PLAY;
        r_bcd    <= '0;
        r_cnt    <= '0;
        r_winner <= '0;
        r_wvalid <= 1'b0;
      end else if (bus.pause) begin
        if (r_state == PLAY || r_state == HOLD) begin
          r_saved <= r_state;
          r_state <= PAUSED;
        end else if (r_state == PAUSED) r_state <= r_saved;
      end else if (r_state == PLAY && |bus.point) begin
        r_bcd   <= w_inc;
        r_event <= 1'b1;
        if (|w_hit) begin
          r_state  <= OVER;
          r_winner <= w_win_idx;
          r_wvalid <= 1'b1;
        end else begin
          r_state <= HOLD;
          r_cnt   <= 8'(HOLD_FRAMES);
        end
      end else if (r_state == HOLD && bus.frame_tick) begin
        r_cnt <= r_cnt - 8'd1;
        if (r_cnt == 8'd1) r_state <= PLAY;
      end
    end
  end
  assign bus.bcd          = r_bcd;
  assign bus.state        = r_state;
  assign bus.freeze       = r_state != PLAY;
  assign bus.score_event  = r_event;
  assign bus.winner       = r_winner;
  assign bus.winner_valid = r_wvalid;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: three score_keeper configurations driven in lockstep, checked by an integer-score model
module tb_score_keeper;
  localparam int S_IDLE = 0, S_PLAY = 1, S_HOLD = 2, S_PAUSED = 3, S_OVER = 4;
  logic clk = 1'b0;
  logic rst = 1'b0, st = 1'b0, pa = 1'b0, tk = 1'b0;
  logic [3:0] pt = '0;
  always #5 clk = ~clk;
  score_keeper_if #(.NUM_PLAYERS(2), .DIGITS(2)) if0();
  score_keeper_if #(.NUM_PLAYERS(4), .DIGITS(3)) if1();
  score_keeper_if #(.NUM_PLAYERS(2), .DIGITS(2)) if2();
  assign if0.start = st; assign if0.pause = pa; assign if0.frame_tick = tk; assign if0.point = pt[1:0];
  assign if1.start = st; assign if1.pause = pa; assign if1.frame_tick = tk; assign if1.point = pt;
  assign if2.start = st; assign if2.pause = pa; assign if2.frame_tick = tk; assign if2.point = pt[1:0];
  score_keeper #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(11),  .HOLD_FRAMES(60)) dut0 (.Clk(clk), .Reset(rst), .bus(if0));
  score_keeper #(.NUM_PLAYERS(4), .DIGITS(3), .WIN_SCORE(105), .HOLD_FRAMES(2))  dut1 (.Clk(clk), .Reset(rst), .bus(if1));
  score_keeper #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(0),   .HOLD_FRAMES(1))  dut2 (.Clk(clk), .Reset(rst), .bus(if2));
  logic [47:0] a_bcd[3];
  logic [2:0]  a_st[3];
  logic [1:0]  a_win[3];
  logic        a_fr[3], a_ev[3], a_wv[3];
  assign a_bcd[0] = 48'(if0.bcd); assign a_st[0] = if0.state; assign a_fr[0] = if0.freeze;
  assign a_ev[0] = if0.score_event; assign a_wv[0] = if0.winner_valid; assign a_win[0] = 2'(if0.winner);
  assign a_bcd[1] = 48'(if1.bcd); assign a_st[1] = if1.state; assign a_fr[1] = if1.freeze;
  assign a_ev[1] = if1.score_event; assign a_wv[1] = if1.winner_valid; assign a_win[1] = 2'(if1.winner);
  assign a_bcd[2] = 48'(if2.bcd); assign a_st[2] = if2.state; assign a_fr[2] = if2.freeze;
  assign a_ev[2] = if2.score_event; assign a_wv[2] = if2.winner_valid; assign a_win[2] = 2'(if2.winner);
  function automatic int np_of(input int k); return k == 1 ? 4 : 2; endfunction
  function automatic int dg_of(input int k); return k == 1 ? 3 : 2; endfunction
  function automatic int ws_of(input int k); return k == 0 ? 11 : (k == 1 ? 105 : 0); endfunction
  function automatic int hf_of(input int k); return k == 0 ? 60 : (k == 1 ? 2 : 1); endfunction
  typedef struct {int k; logic [47:0] bcd; int st; bit ev; bit wv; int win;} exp_t;
  exp_t q[$];
  int m_state[3], m_saved[3], m_cnt[3], m_ev[3], m_wv[3], m_win[3];
  int m_score[3][4];
  int n_checks = 0, n_fail = 0;
  task automatic chk(input string nm, input int k, input logic [63:0] a, input logic [63:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", nm, k, $time, a, e);
    end
  endtask
  task automatic model(input int k);
    int n, mx, hit;
    n = np_of(k);
    mx = 10**dg_of(k) - 1;
    if (rst) begin
      m_state[k] = S_IDLE; m_saved[k] = S_PLAY; m_cnt[k] = 0; m_ev[k] = 0; m_wv[k] = 0; m_win[k] = 0;
      for (int i = 0; i < 4; i++) m_score[k][i] = 0;
      return;
    end
    m_ev[k] = 0;
    if (st) begin
      m_state[k] = S_PLAY; m_cnt[k] = 0; m_wv[k] = 0;
      for (int i = 0; i < 4; i++) m_score[k][i] = 0;
    end else if (pa) begin
      if (m_state[k] == S_PLAY || m_state[k] == S_HOLD) begin
        m_saved[k] = m_state[k];
        m_state[k] = S_PAUSED;
      end else if (m_state[k] == S_PAUSED) m_state[k] = m_saved[k];
    end else if (m_state[k] == S_PLAY && (pt & 4'((1 << n) - 1)) != 0) begin
      m_ev[k] = 1;
      hit = -1;
      for (int i = 0; i < n; i++) if (pt[i] && m_score[k][i] < mx) m_score[k][i]++;
      for (int i = n-1; i >= 0; i--) if (ws_of(k) != 0 && m_score[k][i] == ws_of(k)) hit = i;
      if (hit >= 0) begin
        m_state[k] = S_OVER; m_wv[k] = 1; m_win[k] = hit;
      end else begin
        m_state[k] = S_HOLD; m_cnt[k] = hf_of(k);
      end
    end else if (m_state[k] == S_HOLD && tk) begin
      m_cnt[k]--;
      if (m_cnt[k] == 0) m_state[k] = S_PLAY;
    end
  endtask
  task automatic push(input int k);
    exp_t e;
    e.k = k; e.bcd = '0; e.st = m_state[k]; e.ev = m_ev[k] != 0; e.wv = m_wv[k] != 0; e.win = m_win[k];
    for (int i = 0; i < np_of(k); i++)
      for (int d = 0; d < dg_of(k); d++)
        e.bcd[(i*dg_of(k)+d)*4 +: 4] = 4'((m_score[k][i] / (10**d)) % 10);
    q.push_back(e);
  endtask
  task automatic step(input bit r, input bit s, input bit p, input bit t, input logic [3:0] pv);
    rst = r; st = s; pa = p; tk = t; pt = pv;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      model(k);
      push(k);
    end
    rst = 0; st = 0; pa = 0; tk = 0; pt = '0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 4'b0000);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("bcd", e.k, 64'(a_bcd[e.k]), 64'(e.bcd));
        chk("state", e.k, 64'(a_st[e.k]), 64'(e.st));
        chk("freeze", e.k, 64'(a_fr[e.k]), 64'(e.st != S_PLAY));
        chk("score_event", e.k, 64'(a_ev[e.k]), 64'(e.ev));
        chk("winner_valid", e.k, 64'(a_wv[e.k]), 64'(e.wv));
        if (e.wv) chk("winner", e.k, 64'(a_win[e.k]), 64'(e.win));
      end
    end
  end
  initial begin : stim
    int r;
    logic [3:0] rp;
    step(1, 0, 0, 0, 4'b0000);
    step(1, 0, 0, 1, 4'b1111);
    step(0, 0, 1, 0, 4'b0011);
    // basic count, points during hold, hold expiry
    step(0, 1, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 4'b0001);
    step(0, 0, 0, 0, 4'b0000);
    ticks(30);
    step(0, 0, 0, 0, 4'b0001);
    ticks(30);
    // pause inside hold freezes the counter
    step(0, 0, 0, 0, 4'b0001);
    ticks(20);
    step(0, 0, 1, 0, 4'b0000);
    ticks(100);
    step(0, 0, 1, 1, 4'b0000);
    ticks(39);
    step(0, 0, 0, 1, 4'b0000);
    step(0, 0, 1, 0, 4'b0001);
    step(0, 0, 1, 0, 4'b0000);
    // tie at the winning score
    step(0, 1, 0, 0, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 4'b0011);
      ticks(60);
    end
    step(0, 0, 0, 0, 4'b0011);
    step(0, 0, 1, 1, 4'b0011);
    step(0, 1, 0, 0, 4'b0000);
    step(0, 0, 0, 0, 4'b1010);
    // long run on one player: carry, saturation, wide-instance win
    step(0, 1, 0, 0, 4'b0000);
    for (int i = 0; i < 106; i++) begin
      step(0, 0, 0, 0, 4'b0010);
      ticks(2);
    end
    step(1, 1, 0, 0, 4'b0000);
    step(0, 1, 0, 0, 4'b0000);
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      rp = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      step(r < 2, r >= 2 && r < 5, r >= 5 && r < 35, $urandom_range(0, 9) < 4, rp);
    end
    @(negedge clk);
    @(negedge clk);
    chk("drain", 0, 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
